// File: rtl/divide_signed_seq_pkg.sv
// divide_pkg: shared state encoding and saturation helper for the signed divider
package divide_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
  localparam int MAXW = 64;
  function automatic logic signed [MAXW-1:0] sat_signed(input logic signed [MAXW-1:0] value, input int width, output logic ovf);
    logic signed [MAXW-1:0] hi, lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    ovf = value > hi || value < lo;
    return value > hi ? hi : value < lo ? lo : value;
  endfunction
endpackage

// File: rtl/divide_signed_seq_if.sv
// divide_signed_seq_if: start/busy/valid handshake and operand/result bus of the divider
interface divide_signed_seq_if #(
  parameter int N_BITS_DIVIDEND = 16,
  parameter int N_BITS_DIVISOR  = 8,
  parameter int N_BITS_QUOTIENT = 16
);
  logic start;
  logic [N_BITS_DIVIDEND-1:0] dividend;
  logic [N_BITS_DIVISOR-1:0] divisor;
  logic busy;
  logic valid;
  logic [N_BITS_QUOTIENT-1:0] quotient;
  logic [N_BITS_DIVISOR-1:0] remainder;
  logic dbz;
  logic ovf;
  modport master(output start, dividend, divisor, input busy, valid, quotient, remainder, dbz, ovf);
  modport slave(input start, dividend, divisor, output busy, valid, quotient, remainder, dbz, ovf);
endinterface

// File: rtl/divide_signed_seq_abs_split.sv
// abs_split: two's complement operand into unsigned magnitude and sign (most negative value maps to 2^(W-1))
module abs_split #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] mag,
  output logic         neg
);
  assign neg = x[W-1];
  assign mag = neg ? -x : x;
endmodule

// File: rtl/divide_signed_seq.sv
// divide_signed_seq: iterative signed restoring divider with saturation and divide-by-zero reporting
module divide_signed_seq
  import divide_pkg::*;
#(
  parameter int N_BITS_DIVIDEND = 16,
  parameter int N_BITS_DIVISOR  = 8,
  parameter int N_BITS_QUOTIENT = 16
) (
  input logic clk,
  input logic rst_n,
  divide_signed_seq_if.slave bus
);
  localparam int ND = N_BITS_DIVIDEND;
  localparam int NS = N_BITS_DIVISOR;
  localparam int QW = N_BITS_QUOTIENT;
  localparam int CW = $clog2(ND);
  localparam logic [QW-1:0] QMAX = {1'b0, {(QW-1){1'b1}}};
  localparam logic [QW-1:0] QMIN = {1'b1, {(QW-1){1'b0}}};
  div_state_t state, state_nxt;
  logic [ND-1:0] dvd, a_mag, dvd_step;
  logic [NS-1:0] dmag, b_mag, pr, pr_step, r_nxt;
  logic [NS:0] pr_sh;
  logic [CW-1:0] cnt;
  logic signed [ND:0] q_full;
  logic [QW-1:0] q_sat, q_nxt;
  logic a_neg, b_neg, sign_q, sign_r, accept, dz, last, ge, ld, s_ovf;
  abs_split #(.W(ND)) u_abs_a (.x(bus.dividend), .mag(a_mag), .neg(a_neg));
  abs_split #(.W(NS)) u_abs_b (.x(bus.divisor), .mag(b_mag), .neg(b_neg));
  assign bus.busy  = state == CALC;
  assign bus.valid = state == DONE;
  // state register; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // next state, one restoring step, and the signed/saturated result to load on entering DONE
  always_comb begin
    accept = bus.start && state != CALC;
    dz = bus.divisor == '0;
    last = state == CALC && cnt == '0;
    pr_sh = {pr, dvd[ND-1]};
    ge = pr_sh >= {1'b0, dmag};
    pr_step = ge ? NS'(pr_sh - {1'b0, dmag}) : pr_sh[NS-1:0];
    dvd_step = {dvd[ND-2:0], ge};
    q_full = sign_q ? -$signed({1'b0, dvd_step}) : $signed({1'b0, dvd_step});
    q_sat = QW'(sat_signed({{(MAXW-ND-1){q_full[ND]}}, q_full}, QW, s_ovf));
    q_nxt = last ? q_sat : a_neg ? QMIN : QMAX;
    r_nxt = last ? (sign_r ? -pr_step : pr_step) : '0;
    ld = last || (accept && dz);
    state_nxt = accept ? (dz ? DONE : CALC) : last ? DONE : state == CALC ? CALC : IDLE;
  end
  // operand capture, shift/subtract iteration (quotient bits fill dvd from the LSB) and result registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dvd <= '0;
      dmag <= '0;
      pr <= '0;
      cnt <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      bus.quotient <= '0;
      bus.remainder <= '0;
      bus.dbz <= 1'b0;
      bus.ovf <= 1'b0;
    end else begin
      if (accept) begin
        dvd <= a_mag;
        dmag <= b_mag;
        pr <= '0;
        cnt <= CW'(ND - 1);
        sign_q <= a_neg ^ b_neg;
        sign_r <= a_neg;
      end else if (state == CALC) begin
        dvd <= dvd_step;
        pr <= pr_step;
        cnt <= cnt - 1'b1;
      end
      if (ld) begin
        bus.quotient <= q_nxt;
        bus.remainder <= r_nxt;
        bus.dbz <= !last;
        bus.ovf <= last && s_ovf;
      end
    end
endmodule

// File: tb/tb_divide_signed_seq.sv
// tb_divide_signed_seq: directed vectors against an arithmetic reference model, checked every cycle
module tb_divide_signed_seq;
  localparam int ND = 16;
  typedef struct {longint at; longint qa; longint qb; longint r; bit dz; bit oa; bit ob;} exp_t;
  logic clk = 0, rst_n = 0, start = 0;
  logic [15:0] dividend = '0;
  logic [7:0] divisor = '0;
  int ntests = 0, nfail = 0;
  exp_t sb[$];
  longint e = 0, next_ok = 0, busy_until = -10;
  longint lqa = 0, lqb = 0, lr = 0;
  bit ldz = 0, loa = 0, lob = 0;
  longint va[14] = '{-1000, 1000, -1000, -32768, -32768, 5, -5, 1000, -1000, 0, 127, -128, 32767, -1};
  longint vb[14] = '{7, -7, -7, 1, -1, 0, 0, 3, 3, -3, -128, -128, -128, 2};
  always #5 clk = ~clk;
  divide_signed_seq_if #(.N_BITS_DIVIDEND(16), .N_BITS_DIVISOR(8), .N_BITS_QUOTIENT(16)) ifa ();
  divide_signed_seq_if #(.N_BITS_DIVIDEND(16), .N_BITS_DIVISOR(8), .N_BITS_QUOTIENT(8)) ifb ();
  assign ifa.start = start;
  assign ifa.dividend = dividend;
  assign ifa.divisor = divisor;
  assign ifb.start = start;
  assign ifb.dividend = dividend;
  assign ifb.divisor = divisor;
  divide_signed_seq #(.N_BITS_DIVIDEND(16), .N_BITS_DIVISOR(8), .N_BITS_QUOTIENT(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  divide_signed_seq #(.N_BITS_DIVIDEND(16), .N_BITS_DIVISOR(8), .N_BITS_QUOTIENT(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  function automatic void model(input longint a, input longint b, input int qw, output longint q, output longint r, output bit dz, output bit ov);
    longint hi, lo;
    hi = (64'sd1 <<< (qw - 1)) - 1;
    lo = -hi - 1;
    dz = b == 0;
    ov = 0;
    r = 0;
    if (dz) q = a >= 0 ? hi : lo;
    else begin
      q = a / b;
      r = a % b;
      ov = q > hi || q < lo;
      if (q > hi) q = hi;
      else if (q < lo) q = lo;
    end
  endfunction
  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sb.delete();
      e = 0;
      next_ok = 0;
      busy_until = -10;
    end else begin
      if (start && e >= next_ok) begin
        exp_t x;
        model(longint'($signed(dividend)), longint'($signed(divisor)), 16, x.qa, x.r, x.dz, x.oa);
        model(longint'($signed(dividend)), longint'($signed(divisor)), 8, x.qb, x.r, x.dz, x.ob);
        x.at = x.dz ? e : e + ND;
        next_ok = x.at + 1;
        busy_until = x.dz ? -10 : e + ND - 1;
        sb.push_back(x);
      end
      e++;
    end
  always @(negedge clk) begin
    bit ev;
    if (!rst_n) begin
      lqa = 0; lqb = 0; lr = 0; ldz = 0; loa = 0; lob = 0;
    end
    ev = sb.size() > 0 && sb[0].at == e - 1;
    if (ev) begin
      lqa = sb[0].qa; lqb = sb[0].qb; lr = sb[0].r; ldz = sb[0].dz; loa = sb[0].oa; lob = sb[0].ob;
      void'(sb.pop_front());
    end
    chk("valid_a", ifa.valid, ev);
    chk("valid_b", ifb.valid, ev);
    chk("busy_a", ifa.busy, (e - 1) <= busy_until);
    chk("busy_b", ifb.busy, (e - 1) <= busy_until);
    chk("quot_a", $signed(ifa.quotient), lqa);
    chk("quot_b", $signed(ifb.quotient), lqb);
    chk("rem_a", $signed(ifa.remainder), lr);
    chk("rem_b", $signed(ifb.remainder), lr);
    chk("dbz_a", ifa.dbz, ldz);
    chk("dbz_b", ifb.dbz, ldz);
    chk("ovf_a", ifa.ovf, loa);
    chk("ovf_b", ifb.ovf, lob);
  end
  task automatic op(input longint a, input longint b, input int wait_n);
    start = 1;
    dividend = 16'(a);
    divisor = 8'(b);
    @(posedge clk); #1;
    start = 0;
    dividend = 16'($urandom);
    divisor = 8'($urandom);
    repeat (wait_n) @(posedge clk);
    #1;
  endtask
  initial begin
    longint q, r;
    bit dz, ov;
    model(1000, 7, 16, q, r, dz, ov);
    chk("pin_1000_7_q", q, 142); chk("pin_1000_7_r", r, 6);
    model(-1000, -7, 16, q, r, dz, ov);
    chk("pin_n1000_n7_q", q, 142); chk("pin_n1000_n7_r", r, -6);
    model(1000, -7, 16, q, r, dz, ov);
    chk("pin_1000_n7_q", q, -142); chk("pin_1000_n7_r", r, 6);
    model(1000, 3, 8, q, r, dz, ov);
    chk("pin_qw8_q", q, 127); chk("pin_qw8_ovf", ov, 1); chk("pin_qw8_r", r, 1);
    model(-1000, 3, 8, q, r, dz, ov);
    chk("pin_qw8n_q", q, -128); chk("pin_qw8n_r", r, -1);
    model(-5, 0, 16, q, r, dz, ov);
    chk("pin_dbz_q", q, -32768); chk("pin_dbz_flag", dz, 1);
    model(-32768, 1, 16, q, r, dz, ov);
    chk("pin_min_q", q, -32768); chk("pin_min_ovf", ov, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    start = 1; dividend = 16'd1000; divisor = 8'd7;
    @(posedge clk); #1;
    start = 0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("lat_busy_16", ifa.busy, 1);
    chk("lat_novalid_16", ifa.valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_valid_17", ifa.valid, 1);
    chk("lat_q_142", $signed(ifa.quotient), 142);
    chk("lat_r_6", $signed(ifa.remainder), 6);
    @(posedge clk); #1;
    for (int i = 0; i < 14; i++) op(va[i], vb[i], ND + 2);
    start = 1; dividend = 16'd1234; divisor = 8'(-9);
    @(posedge clk); #1;
    dividend = 16'(-2000); divisor = 8'd13;
    repeat (17) @(posedge clk);
    #1 start = 0;
    repeat (5) @(posedge clk);
    #1 start = 1; dividend = 16'd1; divisor = 8'd1;
    @(posedge clk); #1 start = 0;
    repeat (20) @(posedge clk);
    #1 start = 1; dividend = 16'd5; divisor = 8'd0;
    @(posedge clk); #1 dividend = 16'(-7);
    @(posedge clk); #1 dividend = 16'd100; divisor = 8'd10;
    @(posedge clk); #1 start = 0;
    repeat (20) @(posedge clk);
    #1;
    op(1000, 7, 5);
    #1 rst_n = 0;
    #1;
    chk("rst_busy", ifa.busy, 0);
    chk("rst_valid", ifa.valid, 0);
    chk("rst_q_a", $signed(ifa.quotient), 0);
    chk("rst_q_b", $signed(ifb.quotient), 0);
    chk("rst_r", $signed(ifa.remainder), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    start = 1; dividend = 16'd100; divisor = 8'd10;
    @(posedge clk); #1 start = 0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("post_rst_novalid", ifa.valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_valid", ifa.valid, 1);
    chk("post_rst_q", $signed(ifa.quotient), 10);
    chk("post_rst_r", $signed(ifa.remainder), 0);
    repeat (4) @(posedge clk);
    #1;
    chk("drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
